// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: elastic write-back pipeline of DEPTH register stages between
// the last execute stage and the register file. Each stage holds a valid bit
// and a {pc, wb enable, value, destination} payload.
// Optional build macro WB_STAGE_PIPE_FWD_EN compiles in the forwarding lookup
// (youngest held entry writing i_Query_Reg); without it the forwarding ports
// are tied to zero and i_Query_Reg is ignored.
//
// Handshake: an upstream transfer happens on a rising edge where
// i_Valid && o_Ready; a downstream transfer happens on a rising edge where
// o_Valid && i_Ready. o_Ready depends combinationally on i_Ready through the
// ready chain, so a full pipe that is draining still accepts a new entry in
// the same cycle. The payload is held stable while o_Valid && !i_Ready.
module wb_stage_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEST_WIDTH = 4,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [PC_WIDTH-1:0]   i_Pc,
  input  logic                  i_Sig_Write_Back_Enable,
  input  logic [DATA_WIDTH-1:0] i_Write_Back_Value,
  input  logic [DEST_WIDTH-1:0] i_Destination,
  input  logic                  i_Flush,
  input  logic                  i_Ready,
  output logic                  o_Valid,
  output logic [PC_WIDTH-1:0]   o_Pc,
  output logic                  o_Sig_Write_Back_Enable,
  output logic [DATA_WIDTH-1:0] o_Write_Back_Value,
  output logic [DEST_WIDTH-1:0] o_Destination,
  input  logic [DEST_WIDTH-1:0] i_Query_Reg,
  output logic                  o_Fwd_Hit,
  output logic [DATA_WIDTH-1:0] o_Fwd_Value
);

  // Reject unsupported depths at elaboration time.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("wb_stage_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  // Held stage state; index 0 is the input stage, DEPTH-1 the output stage.
  logic                  vld_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q  [DEPTH];
  logic                  en_q  [DEPTH];
  logic [DATA_WIDTH-1:0] val_q [DEPTH];
  logic [DEST_WIDTH-1:0] dst_q [DEPTH];

  // What each stage would capture if it loads: upstream input or previous stage.
  logic                  src_vld [DEPTH];
  logic [PC_WIDTH-1:0]   src_pc  [DEPTH];
  logic                  src_en  [DEPTH];
  logic [DATA_WIDTH-1:0] src_val [DEPTH];
  logic [DEST_WIDTH-1:0] src_dst [DEPTH];

  // Per-stage load enable from the ready chain.
  logic                  ld [DEPTH];

  // Select the source of every stage: the upstream port or the stage before it.
  always_comb begin
    src_vld[0] = i_Valid;
    src_pc[0]  = i_Pc;
    src_en[0]  = i_Sig_Write_Back_Enable;
    src_val[0] = i_Write_Back_Value;
    src_dst[0] = i_Destination;
    for (int s = 1; s < DEPTH; s++) begin
      src_vld[s] = vld_q[s-1];
      src_pc[s]  = pc_q[s-1];
      src_en[s]  = en_q[s-1];
      src_val[s] = val_q[s-1];
      src_dst[s] = dst_q[s-1];
    end
  end

  // Ready chain: a stage loads when empty or when its entry moves on this cycle;
  // the output stage moves when downstream consumes it.
  always_comb begin
    logic nxt_ld;
    nxt_ld = i_Ready;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      ld[s]  = !vld_q[s] || nxt_ld;
      nxt_ld = ld[s];
    end
  end

  // Stage registers: flush drops every entry (payload left as is), otherwise a
  // loading stage takes its source; payload only changes when a real entry lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= 1'b0;
        pc_q[s]  <= '0;
        en_q[s]  <= 1'b0;
        val_q[s] <= '0;
        dst_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        if (i_Flush) begin
          vld_q[s] <= 1'b0;
        end else if (ld[s]) begin
          vld_q[s] <= src_vld[s];
          if (src_vld[s]) begin
            pc_q[s]  <= src_pc[s];
            en_q[s]  <= src_en[s];
            val_q[s] <= src_val[s];
            dst_q[s] <= src_dst[s];
          end
        end
      end
    end
  end

  // Upstream ready: forced high during flush, forced low while reset is held.
  assign o_Ready = reset && (i_Flush || ld[0]);

  // Output stage payload; the write enable is qualified by the valid bit.
  assign o_Valid                 = vld_q[DEPTH-1];
  assign o_Pc                    = pc_q[DEPTH-1];
  assign o_Sig_Write_Back_Enable = en_q[DEPTH-1] && vld_q[DEPTH-1];
  assign o_Write_Back_Value      = val_q[DEPTH-1];
  assign o_Destination           = dst_q[DEPTH-1];

`ifdef WB_STAGE_PIPE_FWD_EN
  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    o_Fwd_Hit   = 1'b0;
    o_Fwd_Value = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (vld_q[s] && en_q[s] && (dst_q[s] == i_Query_Reg)) begin
        o_Fwd_Hit   = 1'b1;
        o_Fwd_Value = val_q[s];
      end
    end
  end
`else
  // Forwarding not built: ports tied off, query index deliberately unused.
  logic unused_query;
  assign unused_query = ^i_Query_Reg;
  assign o_Fwd_Hit    = 1'b0;
  assign o_Fwd_Value  = '0;
`endif

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of i_Write_Back_Value/o_Write_Back_Value and o_Fwd_Value.
REQ-002 Parameter PC_WIDTH, default 32: width of i_Pc/o_Pc.
REQ-003 Parameter DEST_WIDTH, default 4: width of i_Destination/o_Destination/i_Query_Reg.
REQ-004 Parameter DEPTH, default 1, legal 1..4: number of register stages; any other value is a elaboration error.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 i_Valid  input  1  upstream entry present this cycle.
REQ-008 o_Ready  output  1  pipe accepts an entry this cycle.
REQ-009 i_Pc  input  PC_WIDTH  PC of incoming entry.
REQ-010 i_Sig_Write_Back_Enable  input  1  incoming entry writes the register file.
REQ-011 i_Write_Back_Value  input  DATA_WIDTH  value to write.
REQ-012 i_Destination  input  DEST_WIDTH  destination register index.
REQ-013 i_Flush  input  1  synchronous discard of all held entries.
REQ-014 i_Ready  input  1  downstream (register file) consumes the output entry.
REQ-015 o_Valid  output  1  output stage holds a valid entry.
REQ-016 o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination  output  PC_WIDTH/1/DATA_WIDTH/DEST_WIDTH  payload of last stage.
REQ-017 i_Query_Reg  input  DEST_WIDTH  register index looked up for forwarding.
REQ-018 o_Fwd_Hit  output  1  a held entry will write i_Query_Reg.
REQ-019 o_Fwd_Value  output  DATA_WIDTH  value of the matching entry.

Function
REQ-020 Each stage s (0 = input, DEPTH-1 = output) SHALL hold a valid bit and a payload {Pc, WB enable, value, destination}.
REQ-021 Stage s SHALL be able to load when it is empty or its contents move on this cycle; stage DEPTH-1 moves when o_Valid && i_Ready.
REQ-022 o_Ready SHALL equal the stage-0 load condition, computed combinationally (ready chain, no bubble penalty); a transfer occurs when i_Valid && o_Ready.
REQ-023 With i_Ready held 1 and no flush, an entry accepted at edge N SHALL appear on outputs after edge N+DEPTH-1 (DEPTH cycles latency), throughput one entry per cycle.
REQ-024 A stalled stage SHALL hold its payload unchanged; no entry SHALL be duplicated, dropped or reordered.
REQ-025 o_Sig_Write_Back_Enable SHALL equal stored enable AND o_Valid; payload ports otherwise show the stored value.
REQ-026 i_Flush=1 at an edge SHALL clear every valid bit; an entry offered the same cycle SHALL be discarded; o_Ready SHALL be 1 while i_Flush=1; payload registers not required to clear.
REQ-027 Flush and i_Ready=1 in the same cycle: the output entry SHALL count as consumed this cycle, then be cleared.
REQ-028 Forwarding: among stages with valid=1, enable=1, destination==i_Query_Reg, the youngest (lowest s) SHALL drive o_Fwd_Value and o_Fwd_Hit=1; no match gives o_Fwd_Hit=0, o_Fwd_Value=0; purely combinational from held state.
REQ-029 Entries in flight at reset assertion SHALL be lost; no partial transfer SHALL be reported.

Reset
REQ-030 reset=0 SHALL asynchronously clear all valid bits and payload registers to 0.
REQ-031 During reset: o_Valid=0, o_Pc=0, o_Sig_Write_Back_Enable=0, o_Write_Back_Value=0, o_Destination=0, o_Fwd_Hit=0, o_Fwd_Value=0, o_Ready=0.
REQ-032 Release SHALL take effect at the first rising edge after reset=1; o_Ready=1 from release.

Configuration
REQ-033 Macro WB_STAGE_PIPE_FWD_EN defined: forwarding per REQ-028 compiled in.
REQ-034 Macro undefined: no forwarding compare logic; ports remain, o_Fwd_Hit=0 and o_Fwd_Value=0 constantly; i_Query_Reg ignored.

Verification
REQ-035 DEPTH=1, i_Ready=1: send Pc=0x1000, en=1, value=0xABCD1234, dest=0xA -> next cycle o_Valid=1 with those values; following cycle o_Valid=0.
REQ-036 DEPTH=3, i_Ready=0, stream 4 entries Pc 0x2000..0x200C -> 3 accepted, o_Ready=0 on 4th; raise i_Ready -> outputs 0x2000,0x2004,0x2008,0x200C on consecutive cycles.
REQ-037 DEPTH=2, two entries held, pulse i_Flush with i_Valid=1 Pc=0x3000 -> o_Valid=0 next cycle, 0x3000 never appears.
REQ-038 FWD_EN, DEPTH=3: stages hold dest 5 values 0x11 (oldest) and 0x22 (younger), i_Query_Reg=5 -> o_Fwd_Hit=1, o_Fwd_Value=0x22; entry with en=0 dest 5 ignored; without macro o_Fwd_Hit=0.
REQ-039 Drive reset=0 mid-clock-period with entries in flight -> all outputs 0 immediately (before next edge); after release, Pc=0xFFEEDDCC entry passes with DEPTH latency.
